line_arbiter_n: RTL and testbench

Parametrised N-port cacheline arbiter. It multiplexes up to NUM_PORTS cache-side physical-memory requesters onto one cacheline_adaptor-facing line interface, and replaces the fixed two-port I/D arbiter. One transaction is in flight at a time. Grant policy is round-robin, or fixed priority when compiled out (see Configuration). It sits between the per-core or per-level caches and cacheline_adaptor in the mp4 top level.

---
 rtl/line_arbiter_n.sv | 224 ++++++++++++++++++++++
 tb/tb_line_arbiter_n.sv | 374 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/line_arbiter_n.sv
// line_arbiter_n: N-port cacheline arbiter between the caches and cacheline_adaptor.
// One line transaction is in flight at a time. Selection is round-robin when
// ARB_ROUND_ROBIN_EN is defined, otherwise fixed priority with port 0 highest.
// A port that has just been serviced is masked for the single IDLE cycle that
// follows its response, so a requester that has not yet dropped its request
// cannot be granted twice in a row.
module line_arbiter_n #(
    parameter int NUM_PORTS  = 2,
    parameter int ADDR_WIDTH = 32,
    parameter int LINE_WIDTH = 256
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0] req_address,
    input  logic [NUM_PORTS-1:0]            req_read,
    input  logic [NUM_PORTS-1:0]            req_write,
    input  logic [NUM_PORTS*LINE_WIDTH-1:0] req_wdata,
    output logic [LINE_WIDTH-1:0]           req_rdata,
    output logic [NUM_PORTS-1:0]            req_resp,
    output logic [ADDR_WIDTH-1:0]           pmem_address,
    output logic [LINE_WIDTH-1:0]           pmem_wdata,
    output logic                            pmem_read,
    output logic                            pmem_write,
    input  logic [LINE_WIDTH-1:0]           pmem_rdata,
    input  logic                            pmem_resp
);

    localparam int IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t                 state_q;
    state_t                 state_d;
    logic [IDX_W-1:0]       grant_q;
    logic                   op_read_q;
    logic                   op_write_q;
    logic                   pmem_read_q;
    logic                   pmem_write_q;
    logic                   mask_q;
    logic                   done;
    logic [NUM_PORTS-1:0]   req_vec;
    logic [NUM_PORTS-1:0]   eligible;
    logic                   win_found;
    logic [IDX_W-1:0]       win_idx;
    logic                   win_read;
    logic                   win_write;
    logic [ADDR_WIDTH-1:0]  addr_mux;
    logic [LINE_WIDTH-1:0]  wdata_mux;
    logic [IDX_W-1:0]       grant_next_ptr;

`ifdef ARB_ROUND_ROBIN_EN
    logic [IDX_W-1:0]       rr_ptr;
`endif

    assign req_vec   = req_read | req_write;
    assign done      = (state_q == WAIT) && pmem_resp;
    assign req_rdata = pmem_rdata;

    assign pmem_read  = pmem_read_q;
    assign pmem_write = pmem_write_q;

    // Pointer value following the port that is completing now, wrapping at the top.
    assign grant_next_ptr = (int'(grant_q) == NUM_PORTS - 1) ? '0 : grant_q + 1'b1;

    // Remove the just-serviced port from contention for the one IDLE cycle after its response.
    always_comb begin
        eligible = req_vec;
        if (mask_q) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                if (grant_q == IDX_W'(i)) begin
                    eligible[i] = 1'b0;
                end
            end
        end
    end

`ifdef ARB_ROUND_ROBIN_EN
    // Round-robin pick: lowest eligible index at or above rr_ptr, else lowest index below it.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        win_read  = 1'b0;
        win_write = 1'b0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (!win_found && eligible[i] && (i >= int'(rr_ptr))) begin
                win_found = 1'b1;
                win_idx   = IDX_W'(i);
                win_read  = req_read[i];
                win_write = req_write[i];
            end
        end
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (!win_found && eligible[i] && (i < int'(rr_ptr))) begin
                win_found = 1'b1;
                win_idx   = IDX_W'(i);
                win_read  = req_read[i];
                win_write = req_write[i];
            end
        end
    end
`else
    // Fixed-priority pick: the lowest-numbered eligible port wins.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        win_read  = 1'b0;
        win_write = 1'b0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (!win_found && eligible[i]) begin
                win_found = 1'b1;
                win_idx   = IDX_W'(i);
                win_read  = req_read[i];
                win_write = req_write[i];
            end
        end
    end
`endif

    // Select the granted port's live address and write line.
    always_comb begin
        addr_mux  = '0;
        wdata_mux = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (grant_q == IDX_W'(i)) begin
                addr_mux  = req_address[i*ADDR_WIDTH +: ADDR_WIDTH];
                wdata_mux = req_wdata[i*LINE_WIDTH +: LINE_WIDTH];
            end
        end
    end

    // Address and write data are only presented while a transaction owns the bus.
    always_comb begin
        pmem_address = '0;
        pmem_wdata   = '0;
        if (state_q != IDLE) begin
            pmem_address = addr_mux;
            pmem_wdata   = wdata_mux;
        end
    end

    // Response is a one-cycle pulse to the owner, suppressed while reset is asserted.
    always_comb begin
        req_resp = '0;
        if (done && reset_n) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                if (grant_q == IDX_W'(i)) begin
                    req_resp[i] = 1'b1;
                end
            end
        end
    end

    // Next-state logic: IDLE -> GRANT on a winner, GRANT -> WAIT, WAIT -> IDLE on pmem_resp.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (win_found) begin
                    state_d = GRANT;
                end
            end
            GRANT: begin
                state_d = WAIT;
            end
            WAIT: begin
                if (pmem_resp) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Grant/op capture, registered pmem command, and the one-cycle service mask.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            grant_q      <= '0;
            op_read_q    <= 1'b0;
            op_write_q   <= 1'b0;
            pmem_read_q  <= 1'b0;
            pmem_write_q <= 1'b0;
            mask_q       <= 1'b0;
        end else begin
            if ((state_q == IDLE) && win_found) begin
                grant_q    <= win_idx;
                op_write_q <= win_write;
                op_read_q  <= win_read & ~win_write;
            end
            pmem_read_q  <= (state_d == WAIT) && op_read_q;
            pmem_write_q <= (state_d == WAIT) && op_write_q;
            mask_q       <= done;
        end
    end

`ifdef ARB_ROUND_ROBIN_EN
    // Advance the round-robin pointer past each port as its transaction completes.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rr_ptr <= '0;
        end else if (done) begin
            rr_ptr <= grant_next_ptr;
        end
    end
`else
    logic unused_ptr;
    assign unused_ptr = ^grant_next_ptr;
`endif

endmodule

// File: tb/tb_line_arbiter_n.sv
// tb_line_arbiter_n: self-checking bench for line_arbiter_n with four ports.
// Directed single transactions come from a vector table; multi-cycle corners
// are hand sequences; a random phase is scored against a transaction model.
module tb_line_arbiter_n;

    localparam int NP = 4;
    localparam int AW = 32;
    localparam int LW = 256;

    logic               clk = 1'b0;
    logic               reset_n;
    logic [NP*AW-1:0]   req_address;
    logic [NP-1:0]      req_read;
    logic [NP-1:0]      req_write;
    logic [NP*LW-1:0]   req_wdata;
    logic [LW-1:0]      req_rdata;
    logic [NP-1:0]      req_resp;
    logic [AW-1:0]      pmem_address;
    logic [LW-1:0]      pmem_wdata;
    logic               pmem_read;
    logic               pmem_write;
    logic [LW-1:0]      pmem_rdata;
    logic               pmem_resp;

    line_arbiter_n #(
        .NUM_PORTS  (NP),
        .ADDR_WIDTH (AW),
        .LINE_WIDTH (LW)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .req_address  (req_address),
        .req_read     (req_read),
        .req_write    (req_write),
        .req_wdata    (req_wdata),
        .req_rdata    (req_rdata),
        .req_resp     (req_resp),
        .pmem_address (pmem_address),
        .pmem_wdata   (pmem_wdata),
        .pmem_read    (pmem_read),
        .pmem_write   (pmem_write),
        .pmem_rdata   (pmem_rdata),
        .pmem_resp    (pmem_resp)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          port;
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [255:0] wdata;
        logic [255:0] rdata;
        logic        exp_read;
        logic        exp_write;
        logic [3:0]  exp_resp;
    } vec_t;

    vec_t        vecs [4];
    int          exp_order [4];
    int          checks = 0;
    int          passes = 0;

    logic        port_rd    [NP];
    logic        port_wr    [NP];
    logic [31:0] port_addr  [NP];
    logic [255:0] port_wdata [NP];

    // Record one comparison; mismatches are reported and counted.
    task automatic check_output(input string name, input logic [LW-1:0] actual,
                                input logic [LW-1:0] expected);
        checks++;
        if (actual === expected) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic settle();
        #1;
    endtask

    // Pack the per-port requester state onto the DUT buses.
    task automatic push_inputs();
        for (int p = 0; p < NP; p++) begin
            req_read[p]             = port_rd[p];
            req_write[p]            = port_wr[p];
            req_address[p*AW +: AW] = port_addr[p];
            req_wdata[p*LW +: LW]   = port_wdata[p];
        end
    endtask

    task automatic clear_ports();
        for (int p = 0; p < NP; p++) begin
            port_rd[p]    = 1'b0;
            port_wr[p]    = 1'b0;
            port_addr[p]  = '0;
            port_wdata[p] = '0;
        end
        push_inputs();
    endtask

    task automatic do_reset();
        reset_n    = 1'b0;
        pmem_resp  = 1'b0;
        pmem_rdata = '0;
        clear_ports();
        tick();
        tick();
        reset_n = 1'b1;
        settle();
    endtask

    // Count edges until a pmem command appears; -1 if the bound expires.
    task automatic wait_op(output int edges);
        edges = -1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (pmem_read || pmem_write) begin
                edges = k;
                return;
            end
        end
    endtask

    function automatic logic [255:0] rand_line();
        logic [255:0] v;
        for (int w = 0; w < 8; w++) begin
            v[w*32 +: 32] = $urandom();
        end
        return v;
    endfunction

    // Reference selection: first requesting port at or after ptr, cyclically, skipping masked.
    function automatic int pick(input logic [NP-1:0] reqs, input int masked, input int ptr);
        for (int k = 0; k < NP; k++) begin
            int p;
            p = (ptr + k) % NP;
            if (reqs[p] && (p != masked)) begin
                return p;
            end
        end
        return -1;
    endfunction

    function automatic int port_of_address(input logic [31:0] a);
        for (int p = 0; p < NP; p++) begin
            if ((port_rd[p] || port_wr[p]) && (port_addr[p] == a)) begin
                return p;
            end
        end
        return -1;
    endfunction

    // Run one directed single-port transaction from a clean reset and score it.
    task automatic apply_stimulus(input vec_t v);
        int e;
        do_reset();
        port_rd[v.port]    = v.rd;
        port_wr[v.port]    = v.wr;
        port_addr[v.port]  = v.addr;
        port_wdata[v.port] = v.wdata;
        push_inputs();
        settle();
        wait_op(e);
        check_output("vec_latency", LW'(e), LW'(2));
        check_output("vec_pmem_read", LW'(pmem_read), LW'(v.exp_read));
        check_output("vec_pmem_write", LW'(pmem_write), LW'(v.exp_write));
        check_output("vec_pmem_address", LW'(pmem_address), LW'(v.addr));
        if (v.exp_write) begin
            check_output("vec_pmem_wdata", pmem_wdata, v.wdata);
        end
        check_output("vec_no_early_resp", LW'(req_resp), LW'(0));
        tick();
        check_output("vec_hold_cmd", LW'({pmem_read, pmem_write}), LW'({v.exp_read, v.exp_write}));
        pmem_rdata = v.rdata;
        pmem_resp  = 1'b1;
        settle();
        check_output("vec_req_resp", LW'(req_resp), LW'(v.exp_resp));
        check_output("vec_req_rdata", req_rdata, v.rdata);
        tick();
        pmem_resp = 1'b0;
        clear_ports();
        settle();
        check_output("vec_cmd_drop", LW'({pmem_read, pmem_write}), LW'(0));
        check_output("vec_resp_one_cycle", LW'(req_resp), LW'(0));
    endtask

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int e;
        int got;
        int w;
        int lat;
        int rr;
        int last;
        int kind;
        int waits;
        logic [NP-1:0] reqs;
        logic [NP-1:0] exp_r;
        logic [255:0]  line;

        vecs[0] = '{1, 1'b1, 1'b0, 32'h0000_1040, '0, {8{32'hA5A5_A5A5}}, 1'b1, 1'b0, 4'b0010};
        vecs[1] = '{2, 1'b0, 1'b1, 32'h8000_0000, {8{32'hDEAD_BEEF}}, '0, 1'b0, 1'b1, 4'b0100};
        vecs[2] = '{0, 1'b1, 1'b1, 32'h0000_2000, {8{32'h1234_5678}}, '0, 1'b0, 1'b1, 4'b0001};
        vecs[3] = '{3, 1'b1, 1'b0, 32'hFFFF_FFC0, '0, {8{32'h0F0F_F0F0}}, 1'b1, 1'b0, 4'b1000};

`ifdef ARB_ROUND_ROBIN_EN
        exp_order = '{0, 2, 3, 0};
`else
        exp_order = '{0, 2, 0, 2};
`endif

        // Reset values and a stray response in IDLE.
        do_reset();
        check_output("rst_pmem_read", LW'(pmem_read), LW'(0));
        check_output("rst_pmem_write", LW'(pmem_write), LW'(0));
        check_output("rst_req_resp", LW'(req_resp), LW'(0));
        check_output("rst_pmem_address", LW'(pmem_address), LW'(0));
        check_output("rst_pmem_wdata", pmem_wdata, LW'(0));
        pmem_resp = 1'b1;
        settle();
        check_output("stray_resp_idle", LW'(req_resp), LW'(0));
        tick();
        pmem_resp = 1'b0;
        tick();
        check_output("stray_stays_idle", LW'({pmem_read, pmem_write}), LW'(0));

        // Directed vector table.
        for (int i = 0; i < 4; i++) begin
            apply_stimulus(vecs[i]);
        end

        // Ports 0, 2 and 3 hold requests continuously.
        do_reset();
        for (int p = 0; p < NP; p++) begin
            port_rd[p]   = (p != 1);
            port_addr[p] = 32'h0000_1000 + 32'(p * 64);
        end
        push_inputs();
        settle();
        for (int n = 0; n < 4; n++) begin
            wait_op(e);
            check_output("sim_latency", LW'(e), LW'(2));
            got = port_of_address(pmem_address);
            check_output("sim_grant_order", LW'(got), LW'(exp_order[n]));
            pmem_resp = 1'b1;
            settle();
            exp_r = '0;
            if (exp_order[n] >= 0) exp_r[exp_order[n]] = 1'b1;
            check_output("sim_req_resp", LW'(req_resp), LW'(exp_r));
            tick();
            pmem_resp = 1'b0;
            settle();
        end

        // Reset mid-WAIT, then a late response.
        do_reset();
        port_rd[1]   = 1'b1;
        port_addr[1] = 32'h0000_1040;
        push_inputs();
        settle();
        wait_op(e);
        check_output("rstw_in_wait", LW'(pmem_read), LW'(1));
        tick();
        reset_n   = 1'b0;
        pmem_resp = 1'b1;
        settle();
        check_output("rstw_no_resp_in_reset", LW'(req_resp), LW'(0));
        tick();
        reset_n   = 1'b1;
        pmem_resp = 1'b0;
        clear_ports();
        settle();
        check_output("rstw_read_dropped", LW'(pmem_read), LW'(0));
        check_output("rstw_resp_zero", LW'(req_resp), LW'(0));
        pmem_resp = 1'b1;
        settle();
        check_output("rstw_late_resp", LW'(req_resp), LW'(0));
        tick();
        pmem_resp = 1'b0;
        settle();
        check_output("rstw_still_idle", LW'({pmem_read, pmem_write}), LW'(0));
        port_rd[3]   = 1'b1;
        port_addr[3] = 32'h0000_3300;
        push_inputs();
        settle();
        wait_op(e);
        check_output("rstw_fresh_latency", LW'(e), LW'(2));
        check_output("rstw_fresh_address", LW'(pmem_address), LW'(32'h0000_3300));
        pmem_resp = 1'b1;
        tick();
        pmem_resp = 1'b0;
        clear_ports();

        // Randomised traffic against the transaction-level model.
        do_reset();
        rr   = 0;
        last = -1;
        for (int t = 0; t < 40; t++) begin
            for (int p = 0; p < NP; p++) begin
                if (!port_rd[p] && !port_wr[p] && ($urandom_range(1, 0) == 1)) begin
                    kind          = $urandom_range(2, 0);
                    port_rd[p]    = (kind != 1);
                    port_wr[p]    = (kind != 0);
                    port_addr[p]  = ($urandom() & 32'hFFFF_FF00) | 32'(p);
                    port_wdata[p] = rand_line();
                end
            end
            reqs = '0;
            for (int p = 0; p < NP; p++) reqs[p] = port_rd[p] | port_wr[p];
            if (reqs == '0) begin
                w             = $urandom_range(NP - 1, 0);
                port_rd[w]    = 1'b1;
                port_addr[w]  = ($urandom() & 32'hFFFF_FF00) | 32'(w);
                reqs[w]       = 1'b1;
            end
            push_inputs();
            settle();
            w   = pick(reqs, last, rr);
            lat = 2;
            if (w < 0) begin
                w   = pick(reqs, -1, rr);
                lat = 3;
            end
            wait_op(e);
            check_output("rand_latency", LW'(e), LW'(lat));
            check_output("rand_address", LW'(pmem_address), LW'(port_addr[w]));
            check_output("rand_cmd", LW'({pmem_read, pmem_write}),
                         LW'({port_rd[w] & ~port_wr[w], port_wr[w]}));
            if (port_wr[w]) begin
                check_output("rand_wdata", pmem_wdata, port_wdata[w]);
            end
            waits = $urandom_range(3, 0);
            for (int k = 0; k < waits; k++) begin
                check_output("rand_no_early_resp", LW'(req_resp), LW'(0));
                tick();
            end
            line       = rand_line();
            pmem_rdata = line;
            pmem_resp  = 1'b1;
            settle();
            exp_r    = '0;
            exp_r[w] = 1'b1;
            check_output("rand_req_resp", LW'(req_resp), LW'(exp_r));
            check_output("rand_req_rdata", req_rdata, line);
            tick();
            pmem_resp  = 1'b0;
            port_rd[w] = 1'b0;
            port_wr[w] = 1'b0;
            last       = w;
`ifdef ARB_ROUND_ROBIN_EN
            rr = (w + 1) % NP;
`endif
            check_output("rand_cmd_drop", LW'({pmem_read, pmem_write}), LW'(0));
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
